// File: rtl/uart_pkg.sv
// uart_pkg -- shared types and helpers for the UART transmitter (and the
// future receiver).
//   parity_e   : parity mode encoding (none / even / odd)
//   tx_state_e : transmitter FSM states
//   frame_bits : number of bit periods in one serial frame
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    // start bit + data bits + optional parity bit + stop bits
    function automatic int frame_bits(input int data_w, input int parity, input int stop_bits);
        return 1 + data_w + ((parity != 0) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick -- bit-period timer.
//   clk_t    : system clock
//   srst     : asynchronous active-high reset
//   clear    : restart the bit period (counter to 0 on the next edge)
//   bit_tick : high during the last clk_t cycle of each bit period
// A bit period is exactly CLKS_PER_BIT cycles: the counter runs
// 0..CLKS_PER_BIT-1 and wraps to 0 on the tick.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk_t,
    input  logic srst,
    input  logic clear,
    output logic bit_tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    assign bit_tick = (cnt_reg == LAST_CNT);

    always_comb begin
        cnt_next = cnt_reg + 1'b1;
        if (clear || bit_tick) begin
            cnt_next = '0;
        end
    end

    always_ff @(posedge clk_t or posedge srst) begin
        if (srst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param -- parametrised UART transmitter with a one-entry holding
// buffer. Frames go out LSB-first: start(0), DATA_W data bits, optional
// parity bit, STOP_BITS stop bits(1).
//   clk_t   : system clock
//   srst    : asynchronous active-high reset
//   start   : producer valid; accepted on an edge where start && ready
//   data_in : character, sampled only on acceptance
//   ready   : holding buffer empty (straight from a register)
//   tx      : registered serial output, idles high
//   busy    : FSM not idle or holding buffer full
//   done    : one-cycle pulse after the final stop bit of each frame
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 1,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk_t,
    input  logic              srst,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    output logic              ready,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    generate
        if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
            $error("uart_tx_param: DATA_W must be 5..9");
        end
        if (CLKS_PER_BIT < 2) begin : g_bad_clks
            $error("uart_tx_param: CLKS_PER_BIT must be >= 2");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
            $error("uart_tx_param: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
            $error("uart_tx_param: STOP_BITS must be 1 or 2");
        end
    endgenerate

    localparam parity_e PAR_MODE = (PARITY == 2) ? PAR_ODD :
                                   (PARITY == 1) ? PAR_EVEN : PAR_NONE;
    localparam logic [3:0] LAST_DATA = 4'(DATA_W - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    tx_state_e         state_reg, state_next;
    logic [DATA_W-1:0] shreg_reg, shreg_next;
    logic              par_reg, par_next;
    logic [3:0]        bit_cnt_reg, bit_cnt_next;
    logic [DATA_W-1:0] hold_data_reg, hold_data_next;
    logic              hold_valid_reg, hold_valid_next;
    logic              tx_reg, tx_next;
    logic              done_reg, done_next;
    logic              load;
    logic              accept;
    logic              bit_tick;
    logic              baud_clear;

    assign ready  = !hold_valid_reg;
    assign accept = start && !hold_valid_reg;
    assign tx     = tx_reg;
    assign done   = done_reg;
    assign busy   = (state_reg != IDLE) || hold_valid_reg;

    // Restart the bit period on every state change so each state starts a
    // full CLKS_PER_BIT window; keep it parked at 0 while idle.
    assign baud_clear = (state_reg == IDLE) || (state_next != state_reg);

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk_t   (clk_t),
        .srst    (srst),
        .clear   (baud_clear),
        .bit_tick(bit_tick)
    );

    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        tx_next      = tx_reg;
        done_next    = 1'b0;
        load         = 1'b0;

        case (state_reg)
            IDLE: begin
                tx_next = 1'b1;
                if (hold_valid_reg) begin
                    load       = 1'b1;
                    tx_next    = 1'b0;
                    state_next = START;
                end
            end
            START: begin
                if (bit_tick) begin
                    tx_next      = shreg_reg[0];
                    bit_cnt_next = '0;
                    state_next   = DATA;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    if (bit_cnt_reg == LAST_DATA) begin
                        bit_cnt_next = '0;
                        if (PAR_MODE != PAR_NONE) begin
                            tx_next    = par_reg;
                            state_next = uart_pkg::PARITY;
                        end else begin
                            tx_next    = 1'b1;
                            state_next = STOP;
                        end
                    end else begin
                        // shreg shifts this edge, so the next bit is [1] now
                        tx_next      = shreg_reg[1];
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                    end
                end
            end
            uart_pkg::PARITY: begin
                if (bit_tick) begin
                    tx_next      = 1'b1;
                    bit_cnt_next = '0;
                    state_next   = STOP;
                end
            end
            STOP: begin
                if (bit_tick) begin
                    if (bit_cnt_reg == LAST_STOP) begin
                        done_next    = 1'b1;
                        bit_cnt_next = '0;
                        if (hold_valid_reg) begin
                            // chain straight into the next start bit
                            load       = 1'b1;
                            tx_next    = 1'b0;
                            state_next = START;
                        end else begin
                            tx_next    = 1'b1;
                            state_next = IDLE;
                        end
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                    end
                end
            end
            default: begin
                tx_next    = 1'b1;
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        shreg_next      = shreg_reg;
        par_next        = par_reg;
        hold_data_next  = hold_data_reg;
        hold_valid_next = hold_valid_reg;

        if (load) begin
            shreg_next      = hold_data_reg;
            par_next        = (^hold_data_reg) ^ (PAR_MODE == PAR_ODD);
            hold_valid_next = 1'b0;
        end else if (state_reg == DATA && bit_tick) begin
            shreg_next = shreg_reg >> 1;
        end

        // load needs hold_valid=1 and accept needs hold_valid=0, so they
        // never coincide; a start on the load edge is ignored.
        if (accept) begin
            hold_data_next  = data_in;
            hold_valid_next = 1'b1;
        end
    end

    always_ff @(posedge clk_t or posedge srst) begin
        if (srst) begin
            state_reg      <= IDLE;
            shreg_reg      <= '0;
            par_reg        <= 1'b0;
            bit_cnt_reg    <= '0;
            hold_data_reg  <= '0;
            hold_valid_reg <= 1'b0;
            tx_reg         <= 1'b1;
            done_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            shreg_reg      <= shreg_next;
            par_reg        <= par_next;
            bit_cnt_reg    <= bit_cnt_next;
            hold_data_reg  <= hold_data_next;
            hold_valid_reg <= hold_valid_next;
            tx_reg         <= tx_next;
            done_reg       <= done_next;
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param -- directed bench for uart_tx_param.
// Three instances with CLKS_PER_BIT=4:
//   0: 8 data bits, even parity, 1 stop
//   1: 8 data bits, odd parity, 1 stop
//   2: 7 data bits, no parity, 2 stops
// Inputs change and outputs are sampled on the falling clock edge.
// Expected tx sequences are hand-computed bit vectors, bit i = i-th bit
// period of the frame (start bit first).
module tb_uart_tx_param;

    localparam int CPB = 4;

    logic            clk_t = 1'b0;
    logic            srst  = 1'b1;
    logic [2:0]      start_v = '0;
    logic [2:0][8:0] data_v  = '0;
    logic [2:0]      ready_v;
    logic [2:0]      tx_v;
    logic [2:0]      busy_v;
    logic [2:0]      done_v;

    int errors = 0;
    int checks = 0;

    always #5 clk_t = ~clk_t;

    uart_tx_param #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(1)) u_even (
        .clk_t(clk_t), .srst(srst), .start(start_v[0]), .data_in(data_v[0][7:0]),
        .ready(ready_v[0]), .tx(tx_v[0]), .busy(busy_v[0]), .done(done_v[0]));

    uart_tx_param #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(1)) u_odd (
        .clk_t(clk_t), .srst(srst), .start(start_v[1]), .data_in(data_v[1][7:0]),
        .ready(ready_v[1]), .tx(tx_v[1]), .busy(busy_v[1]), .done(done_v[1]));

    uart_tx_param #(.DATA_W(7), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(2)) u_7n2 (
        .clk_t(clk_t), .srst(srst), .start(start_v[2]), .data_in(data_v[2][6:0]),
        .ready(ready_v[2]), .tx(tx_v[2]), .busy(busy_v[2]), .done(done_v[2]));

    // Offer one byte; returns at the falling edge of the first start-bit cycle.
    task automatic send_byte(input int sel, input logic [8:0] d, input string name);
        @(negedge clk_t);
        checks++;
        if (ready_v[sel] !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_before_offer: got %b want 1", name, ready_v[sel]);
        end
        start_v[sel] = 1'b1;
        data_v[sel]  = d;
        @(negedge clk_t);
        start_v[sel] = 1'b0;
        checks++;
        if (ready_v[sel] !== 1'b0 || busy_v[sel] !== 1'b1) begin
            errors++;
            $display("FAIL %s accept: got ready=%b busy=%b want ready=0 busy=1",
                     name, ready_v[sel], busy_v[sel]);
        end
        @(negedge clk_t);
    endtask

    // Check tx over a frame from cycle c0, optionally offering another byte
    // at cycle offer_at. Returns at the cycle after the final stop bit and
    // checks the done pulse there.
    task automatic capture_frame(input int sel, input logic [15:0] exp, input int nbits,
                                 input int c0, input int offer_at, input logic [8:0] offer_data,
                                 input string name);
        int tx_err = 0;
        int done_err = 0;
        int bad_cyc = -1;
        logic bad_val = 1'b0;
        for (int i = c0; i < nbits * CPB; i++) begin
            if (offer_at >= 0 && i == offer_at) begin
                start_v[sel] = 1'b1;
                data_v[sel]  = offer_data;
            end
            if (offer_at >= 0 && i == offer_at + 1) begin
                start_v[sel] = 1'b0;
                checks++;
                if (ready_v[sel] !== 1'b0 || busy_v[sel] !== 1'b1) begin
                    errors++;
                    $display("FAIL %s mid_frame_accept: got ready=%b busy=%b want ready=0 busy=1",
                             name, ready_v[sel], busy_v[sel]);
                end
            end
            if (tx_v[sel] !== exp[i / CPB]) begin
                if (tx_err == 0) begin
                    bad_cyc = i;
                    bad_val = tx_v[sel];
                end
                tx_err++;
            end
            if (i > 0 && done_v[sel] !== 1'b0) done_err++;
            @(negedge clk_t);
        end
        checks++;
        if (tx_err != 0) begin
            errors++;
            $display("FAIL %s tx_seq: %0d bad cycles, first at cycle %0d got %b want %b",
                     name, tx_err, bad_cyc, bad_val, exp[bad_cyc / CPB]);
        end
        checks++;
        if (done_err != 0) begin
            errors++;
            $display("FAIL %s done_early: done high in %0d cycles inside frame, want 0", name, done_err);
        end
        checks++;
        if (done_v[sel] !== 1'b1) begin
            errors++;
            $display("FAIL %s done_pulse: got %b at cycle %0d want 1", name, done_v[sel], nbits * CPB);
        end
    endtask

    // After the last frame: line idle, buffer empty, done drops next cycle.
    task automatic check_idle_after(input int sel, input string name);
        checks++;
        if (tx_v[sel] !== 1'b1 || busy_v[sel] !== 1'b0 || ready_v[sel] !== 1'b1) begin
            errors++;
            $display("FAIL %s idle_after: got tx=%b busy=%b ready=%b want 1 0 1",
                     name, tx_v[sel], busy_v[sel], ready_v[sel]);
        end
        @(negedge clk_t);
        checks++;
        if (done_v[sel] !== 1'b0 || tx_v[sel] !== 1'b1) begin
            errors++;
            $display("FAIL %s done_width: got done=%b tx=%b want done=0 tx=1",
                     name, done_v[sel], tx_v[sel]);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk_t);
        checks++;
        if (tx_v !== 3'b111 || ready_v !== 3'b111 || busy_v !== 3'b000 || done_v !== 3'b000) begin
            errors++;
            $display("FAIL reset_held: got tx=%b ready=%b busy=%b done=%b want 111 111 000 000",
                     tx_v, ready_v, busy_v, done_v);
        end
        srst = 1'b0;
        repeat (3) @(negedge clk_t);
        checks++;
        if (tx_v !== 3'b111 || ready_v !== 3'b111 || busy_v !== 3'b000 || done_v !== 3'b000) begin
            errors++;
            $display("FAIL reset_release: got tx=%b ready=%b busy=%b done=%b want 111 111 000 000",
                     tx_v, ready_v, busy_v, done_v);
        end
        $display("test_reset done");
    endtask

    task automatic test_even_a5();
        send_byte(0, 9'h0A5, "even_A5");
        capture_frame(0, 16'h054A, 11, 0, -1, 9'h000, "even_A5");
        check_idle_after(0, "even_A5");
        $display("tx 0xA5 8E1 frame checked");
    endtask

    task automatic test_parity_07();
        send_byte(1, 9'h007, "odd_07");
        capture_frame(1, 16'h040E, 11, 0, -1, 9'h000, "odd_07");
        check_idle_after(1, "odd_07");
        $display("tx 0x07 8O1 frame checked");
        send_byte(0, 9'h007, "even_07");
        capture_frame(0, 16'h060E, 11, 0, -1, 9'h000, "even_07");
        check_idle_after(0, "even_07");
        $display("tx 0x07 8E1 frame checked");
    endtask

    task automatic test_7n2();
        send_byte(2, 9'h055, "7n2_55");
        capture_frame(2, 16'h03AA, 10, 0, -1, 9'h000, "7n2_55");
        check_idle_after(2, "7n2_55");
        $display("tx 0x55 7N2 frame checked");
    endtask

    task automatic test_back_to_back();
        send_byte(0, 9'h012, "b2b_12");
        // offer 0x34 at cycle 10, inside the data bits of frame 1
        capture_frame(0, 16'h0424, 11, 0, 10, 9'h034, "b2b_12");
        capture_frame(0, 16'h0668, 11, 0, -1, 9'h000, "b2b_34");
        check_idle_after(0, "b2b_34");
        $display("tx 0x12,0x34 back-to-back frames checked");
    endtask

    task automatic test_start_held();
        @(negedge clk_t);
        checks++;
        if (ready_v[0] !== 1'b1) begin
            errors++;
            $display("FAIL held ready_initial: got %b want 1", ready_v[0]);
        end
        start_v[0] = 1'b1;
        data_v[0]  = 9'h081;
        @(negedge clk_t);
        checks++;
        if (ready_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL held ready_after_accept: got %b want 0", ready_v[0]);
        end
        data_v[0] = 9'h0F0;                 // offered while full: lost
        @(negedge clk_t);
        checks++;
        if (ready_v[0] !== 1'b1 || tx_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL held ready_return: got ready=%b tx=%b want ready=1 tx=0",
                     ready_v[0], tx_v[0]);
        end
        data_v[0] = 9'h099;                 // present when ready returns
        @(negedge clk_t);
        start_v[0] = 1'b0;
        capture_frame(0, 16'h0502, 11, 1, -1, 9'h000, "held_81");
        capture_frame(0, 16'h0532, 11, 0, -1, 9'h000, "held_99");
        check_idle_after(0, "held_99");
        $display("tx held-start 0x81 then 0x99 checked");
    endtask

    task automatic test_reset_mid_frame();
        int bad = 0;
        send_byte(0, 9'h012, "rst_12");
        for (int i = 0; i < 17; i++) begin
            if (i == 8) begin
                start_v[0] = 1'b1;
                data_v[0]  = 9'h034;
            end
            if (i == 9) start_v[0] = 1'b0;
            @(negedge clk_t);
        end
        // cycle 17: inside data bit 3, 0x34 buffered
        checks++;
        if (ready_v[0] !== 1'b0 || busy_v[0] !== 1'b1) begin
            errors++;
            $display("FAIL rst buffered: got ready=%b busy=%b want 0 1", ready_v[0], busy_v[0]);
        end
        srst = 1'b1;
        #1;
        checks++;
        if (tx_v[0] !== 1'b1 || ready_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || done_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL rst async: got tx=%b ready=%b busy=%b done=%b want 1 1 0 0",
                     tx_v[0], ready_v[0], busy_v[0], done_v[0]);
        end
        repeat (2) @(negedge clk_t);
        srst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk_t);
            if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || done_v[0] !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rst stale: %0d cycles with activity after reset, want 0", bad);
        end
        send_byte(0, 9'h03C, "rst_3C");
        capture_frame(0, 16'h0478, 11, 0, -1, 9'h000, "rst_3C");
        check_idle_after(0, "rst_3C");
        $display("tx reset mid-frame then 0x3C checked");
    endtask

    initial begin
        test_reset();
        test_even_a5();
        test_parity_07();
        test_7n2();
        test_back_to_back();
        test_start_held();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
